fifo_sync: RTL and testbench

FIFO_SYNC -- requirements
Module: fifo_sync

---
 rtl/fifo_sync.sv | 117 +++++++++++
 tb/tb_fifo_sync.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync.sv
// Synchronous FIFO with occupancy flags, sticky overflow/underflow and flush.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through reads; default is registered read, latency 1.
module fifo_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = (1 << ADDR_WIDTH),
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_go, rd_go;

  // Flags come only from the registered count, so no request-to-flag path exists.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AFULL_LVL));
  assign almost_empty = (count_q <= CW'(AEMPTY_LVL));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  assign wr_go = wr_en & ~full  & ~flush;
  assign rd_go = rd_en & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is plain overflow of the adder.
      if (wr_go) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_go) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_go, rd_go})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (wr_en && full)  ovf_d = 1'b1;
      if (rd_en && empty) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_go) mem_q[wr_ptr_q] <= wr_data;
  end

`ifdef FIFO_SYNC_FWFT_EN
  assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign rd_valid = ~empty;
`else
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_go;
      if (rd_go) rd_data_q <= mem_q[rd_ptr_q];
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync (DATA_WIDTH=8, ADDR_WIDTH=4); follows FIFO_SYNC_FWFT_EN if defined.
module tb_fifo_sync;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  int nvec = 0;
  int nmis = 0;

  fifo_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // Pop one word (optionally writing in the same cycle) and check it against exp.
  task automatic pop(input string tag, input logic [7:0] exp, input logic wr, input logic [7:0] wd);
`ifdef FIFO_SYNC_FWFT_EN
    chk({tag, "_vld"}, rd_valid, 1);
    chk({tag, "_dat"}, rd_data, exp);
    rd_en = 1'b1; wr_en = wr; wr_data = wd;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
`else
    rd_en = 1'b1; wr_en = wr; wr_data = wd;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    chk({tag, "_vld"}, rd_valid, 1);
    chk({tag, "_dat"}, rd_data, exp);
`endif
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    chk("rst_vld", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // basic order
    push(8'h11); push(8'h22); push(8'h33);
    chk("b_cnt3", count, 3);
    chk("b_empty0", empty, 0);
    pop("b_r0", 8'h11, 1'b0, 8'h00); chk("b_cnt2", count, 2);
    pop("b_r1", 8'h22, 1'b0, 8'h00); chk("b_cnt1", count, 1);
    pop("b_r2", 8'h33, 1'b0, 8'h00); chk("b_cnt0", count, 0);
    chk("b_empty1", empty, 1);
    tick();
    chk("b_vld_drop", rd_valid, 0);

    // fill to full, overflow, full-with-read
    for (int i = 0; i < 16; i++) begin
      push(8'h40 + 8'(i));
      chk("f_afull", almost_full, (i >= 13) ? 1 : 0);
      chk("f_full", full, (i == 15) ? 1 : 0);
    end
    chk("f_cnt16", count, 16);
    chk("f_ovf0", overflow, 0);
    push(8'hEE);
    chk("f_ovf1", overflow, 1);
    chk("f_cnt_hold", count, 16);
    pop("f_rw", 8'h40, 1'b1, 8'hDD);
    chk("f_rw_cnt", count, 15);
    chk("f_rw_full", full, 0);
    for (int i = 1; i < 16; i++) begin
      pop("f_drain", 8'h40 + 8'(i), 1'b0, 8'h00);
      chk("f_aempty", almost_empty, (i >= 13) ? 1 : 0);
    end
    chk("f_empty", empty, 1);
    chk("f_ovf_sticky", overflow, 1);
    do_flush();
    chk("f_ovf_flush", overflow, 0);

    // underflow, empty-with-write, flush override
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("u_udf1", underflow, 1);
    chk("u_vld0", rd_valid, 0);
    chk("u_cnt0", count, 0);
    rd_en = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    chk("u_rw_cnt", count, 1);
`ifdef FIFO_SYNC_FWFT_EN
    chk("u_rw_dat", rd_data, 8'h77);
`else
    chk("u_rw_vld", rd_valid, 0);
`endif
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h55;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    chk("u_fl_udf", underflow, 0);
    chk("u_fl_cnt", count, 0);
    chk("u_fl_empty", empty, 1);

    // steady state at count 5, 40 cycles: 45 writes wrap the pointers twice
    for (int i = 0; i < 5; i++) push(8'h80 + 8'(i));
    chk("s_cnt5", count, 5);
    for (int i = 0; i < 40; i++) begin
      pop("s_rw", 8'h80 + 8'(i), 1'b1, 8'h85 + 8'(i));
      chk("s_cnt", count, 5);
    end
    for (int i = 40; i < 45; i++) pop("s_drain", 8'h80 + 8'(i), 1'b0, 8'h00);
    chk("s_empty", empty, 1);

    // asynchronous reset mid-burst
    for (int i = 0; i < 9; i++) push(8'hC0 + 8'(i));
    chk("r_cnt9", count, 9);
    wr_en = 1'b1; wr_data = 8'h99;
    #2;
    resetn = 1'b0;
    #1;
    chk("r_cnt0", count, 0);
    chk("r_empty", empty, 1);
    chk("r_vld", rd_valid, 0);
    wr_en = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    tick();
    chk("r_still_empty", empty, 1);

    // read latency on a single word
    push(8'hA5);
`ifndef FIFO_SYNC_FWFT_EN
    chk("l_vld_pre", rd_valid, 0);
`endif
    pop("l_a5", 8'hA5, 1'b0, 8'h00);
    chk("l_cnt0", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
